// File: rtl/reg_err_slv_pkg.sv
// Shared types and helpers for the register-interface error slave.
// Holds the per-port latency FSM state encoding, the default reg request and
// response structs, and the popcount / saturating-add helpers used by the
// error counter.
package reg_err_slv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } port_state_e;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } reg_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        error;
    } reg_rsp_t;

    // Number of set bits in a completion vector (up to 64 ports).
    function automatic logic [63:0] popcount(input logic [63:0] vec);
        logic [63:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + {63'd0, vec[i]};
        end
        return n;
    endfunction

    // a + b clamped to max_val; the counter holds at its ceiling instead of wrapping.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [63:0] max_val);
        logic [63:0] sum;
        logic [63:0] res;
        sum = a + b;
        if ((sum > max_val) || (sum < a)) begin
            res = max_val;
        end else begin
            res = sum;
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_err_slv_port.sv
// One port of the error slave: decides when ready is raised for a request.
// Latency == 0 answers combinationally; otherwise a small FSM raises ready
// exactly Latency cycles after valid is first seen, for a single cycle.
module reg_err_slv_port
    import reg_err_slv_pkg::*;
#(
    parameter int unsigned Latency = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid_i,
    output logic ready_o,
    output logic done_o
);

    if (Latency == 0) begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_i;
        assign ready_o        = 1'b1;
        assign done_o         = valid_i;
    end else begin : g_fsm
        localparam int unsigned  CW      = (Latency > 1) ? $clog2(Latency) : 1;
        localparam logic [CW-1:0] LoadVal = CW'(Latency - 1);

        port_state_e   state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;

        // State and wait-counter registers; reset abandons any access in flight.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Next state: the count holds the cycles still to spend before RESP,
        // so RESP is entered when the last WAIT cycle (cnt==1) is reached.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            ready_o = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        cnt_d   = LoadVal;
                        state_d = (Latency == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (!valid_i) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q <= CW'(1)) begin
                        state_d = RESP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    state_d = IDLE;
                    ready_o = valid_i;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        assign done_o = ready_o;
    end

endmodule

// File: rtl/reg_err_slv_logged.sv
// Multi-port register-interface error slave with fault logging.
// Every access completes with error=1 and rdata=ErrVal after Latency cycles.
// With REG_ERR_SLV_LOG_EN defined, the first completed access is captured
// (lowest port wins on a tie) and completions are counted with saturation;
// without it the log outputs and counter read zero and clear_i is ignored.
module reg_err_slv_logged
    import reg_err_slv_pkg::*;
#(
    parameter int unsigned   NumPorts = 1,
    parameter int unsigned   AW       = 32,
    parameter int unsigned   DW       = 32,
    parameter logic [DW-1:0] ErrVal   = '0,
    parameter int unsigned   Latency  = 0,
    parameter int unsigned   CntWidth = 16,
    parameter type           req_t    = reg_req_t,
    parameter type           rsp_t    = reg_rsp_t,
    localparam int unsigned  PortW    = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  req_t [NumPorts-1:0]  req_i,
    output rsp_t [NumPorts-1:0]  rsp_o,
    input  logic                 clear_i,
    output logic                 log_valid_o,
    output logic [AW-1:0]        log_addr_o,
    output logic                 log_write_o,
    output logic [PortW-1:0]     log_port_o,
    output logic [CntWidth-1:0]  err_cnt_o
);

    logic [NumPorts-1:0] port_ready;
    logic [NumPorts-1:0] port_done;

    for (genvar p = 0; p < NumPorts; p++) begin : g_port
        reg_err_slv_port #(
            .Latency (Latency)
        ) u_port (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .valid_i (req_i[p].valid),
            .ready_o (port_ready[p]),
            .done_o  (port_done[p])
        );
    end

    // Responses: only ready varies; data and error are fixed.
    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            rsp_o[p]       = '0;
            rsp_o[p].ready = port_ready[p];
            rsp_o[p].rdata = ErrVal;
            rsp_o[p].error = 1'b1;
        end
    end

    logic unused_req;
    assign unused_req = ^req_i;

`ifdef REG_ERR_SLV_LOG_EN
    localparam logic [63:0] CntMax = 64'((65'd1 << CntWidth) - 65'd1);

    logic                log_valid_q, log_valid_d;
    logic [AW-1:0]       log_addr_q, log_addr_d;
    logic                log_write_q, log_write_d;
    logic [PortW-1:0]    log_port_q, log_port_d;
    logic [CntWidth-1:0] err_cnt_q, err_cnt_d;

    logic                hit;
    logic [AW-1:0]       hit_addr;
    logic                hit_write;
    logic [PortW-1:0]    hit_port;

    // Pick the lowest-indexed completing port by scanning from the top down.
    always_comb begin
        hit       = 1'b0;
        hit_addr  = '0;
        hit_write = 1'b0;
        hit_port  = '0;
        for (int p = NumPorts - 1; p >= 0; p--) begin
            if (port_done[p]) begin
                hit       = 1'b1;
                hit_addr  = req_i[p].addr;
                hit_write = req_i[p].write;
                hit_port  = PortW'(p);
            end
        end
    end

    // Clear first, then record this cycle's completions on top of it.
    always_comb begin
        log_valid_d = log_valid_q;
        log_addr_d  = log_addr_q;
        log_write_d = log_write_q;
        log_port_d  = log_port_q;
        err_cnt_d   = err_cnt_q;
        if (clear_i) begin
            log_valid_d = 1'b0;
            log_addr_d  = '0;
            log_write_d = 1'b0;
            log_port_d  = '0;
            err_cnt_d   = '0;
        end
        if (hit && !log_valid_d) begin
            log_valid_d = 1'b1;
            log_addr_d  = hit_addr;
            log_write_d = hit_write;
            log_port_d  = hit_port;
        end
        err_cnt_d = CntWidth'(sat_add(64'(err_cnt_d), popcount(64'(port_done)), CntMax));
    end

    // Log and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            log_valid_q <= 1'b0;
            log_addr_q  <= '0;
            log_write_q <= 1'b0;
            log_port_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            log_valid_q <= log_valid_d;
            log_addr_q  <= log_addr_d;
            log_write_q <= log_write_d;
            log_port_q  <= log_port_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign log_valid_o = log_valid_q;
    assign log_addr_o  = log_addr_q;
    assign log_write_o = log_write_q;
    assign log_port_o  = log_port_q;
    assign err_cnt_o   = err_cnt_q;
`else
    logic unused_log;
    assign unused_log = clear_i ^ (^port_done);

    assign log_valid_o = 1'b0;
    assign log_addr_o  = '0;
    assign log_write_o = 1'b0;
    assign log_port_o  = '0;
    assign err_cnt_o   = '0;
`endif

endmodule
